// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle-latency ROM and
// buffers {inst, pc} pairs in a 2-entry FIFO for decode. Define FETCH_PERF_EN for perf counters.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_req_v;
  logic [ADDR_W-1:0] r_req_pc;

  logic [31:0]       r_inst_mem [2];
  logic [ADDR_W-1:0] r_pc_mem   [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_credit;

  assign rom_addr  = r_pc;
  assign out_valid = (r_count != 2'd0);
  assign out_inst  = r_inst_mem[r_rd_ptr];
  assign out_pc    = r_pc_mem[r_rd_ptr];

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_req_v & ~redirect_valid;

  // Buffered entries plus the word in flight must leave room for the new request.
  assign w_credit = {1'b0, r_count} + {2'b00, r_req_v} - {2'b00, w_pop};
  assign w_issue  = ~redirect_valid & (w_credit < 3'd2);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_req_v  <= 1'b0;
      r_req_pc <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (redirect_valid) begin
      // The in-flight ROM word and every buffered entry belong to the wrong path.
      r_pc     <= redirect_pc;
      r_req_v  <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_req_v <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + ADDR_W'(1);
      end
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the two storage entries are reset on purpose so that out_inst/out_pc
  // read zero until the first instruction lands after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else if (w_push) begin
      r_inst_mem[r_wr_ptr] <= rom_inst;
      r_pc_mem[r_wr_ptr]   <= r_req_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
      r_perf_flush   <= '0;
    end else begin
      if (w_push)                 r_perf_fetched <= r_perf_fetched + 32'd1;
      if (out_valid & ~out_ready) r_perf_stall   <= r_perf_stall + 32'd1;
      if (redirect_valid)         r_perf_flush   <= r_perf_flush + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
  assign perf_flush   = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a ROM model plus a queue of expected PCs
// that is refilled on every reset/redirect and drained on every handshake.
module tb_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stall;
  logic [31:0]       perf_flush;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q [$];

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush),
`endif
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: registers the address, word n holds 0x1000_0000 + n, aliasing every 1024 words.
  initial rom_inst = 32'h0;
  always @(posedge clk) rom_inst <= 32'h1000_0000 + {22'd0, rom_addr[9:0]};

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return 32'h1000_0000 + (pc & 32'h0000_03FF);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    sb_q.delete();
    for (int i = 0; i < 256; i++) sb_q.push_back(start + 32'(i));
  endtask

  // One clock cycle: drive inputs at the negedge, score any handshake, move to the next negedge.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt, input logic rs);
    logic [31:0] e;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    rst            = rs;
    #1;
    if (!rs && out_valid && rdy) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", out_pc, e);
        check("sb_inst", out_inst, exp_inst(e));
      end
    end
    if (rs)         sb_restart(RESET_PC);
    else if (redir) sb_restart(tgt);
    @(negedge clk);
  endtask

  task automatic run(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0, 1'b0);
  endtask

  // Checks the 3-cycle restart bubble after a reset/redirect already applied;
  // returns in the cycle where the target should be at the buffer head.
  task automatic restart_bubble(input string tag);
    check({tag, "_valid_t1"}, 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check({tag, "_valid_t2"}, 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check({tag, "_valid_t3"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset release and first fetch.
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_rom_addr", rom_addr, RESET_PC);
    restart_bubble("rst");
    check("first_pc", out_pc, RESET_PC);

    // Full-rate streaming.
    for (int i = 0; i < 12; i++) begin
      check("thru_valid", 32'(out_valid), 32'd1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
    end

    // Stall: head must hold, fetch may run at most two words ahead of it.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_pc", out_pc, sb_q[0]);
      check("stall_inst", out_inst, exp_inst(sb_q[0]));
      check("stall_rom_bound", 32'((rom_addr - sb_q[0]) <= 32'd2), 32'd1);
    end
    run(1'b1, 8);

    // Redirect while the buffer is full.
    run(1'b0, 3);
    step(1'b0, 1'b1, 32'h40, 1'b0);
    restart_bubble("redir_full");
    check("redir_full_pc", out_pc, 32'h40);
    run(1'b1, 4);

    // Redirect while streaming with a request in flight.
    step(1'b1, 1'b1, 32'h80, 1'b0);
    restart_bubble("redir_stream");
    check("redir_stream_pc", out_pc, 32'h80);
    run(1'b1, 3);

    // Redirect in the same cycle as the pop of pc 5.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    restart_bubble("rst2");
    for (int i = 0; i < 10 && sb_q[0] != 32'd5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    check("pop5_valid", 32'(out_valid), 32'd1);
    check("pop5_pc", out_pc, 32'd5);
    step(1'b1, 1'b1, 32'h200, 1'b0);
    restart_bubble("redir_pop");
    check("redir_pop_pc", out_pc, 32'h200);
    run(1'b1, 3);

    // PC wrap.
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    restart_bubble("wrap");
    check("wrap_pc0", out_pc, 32'hFFFF_FFFF);
    run(1'b1, 4);

    // Reset in the middle of a stall with a full buffer.
    run(1'b0, 4);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_stall_rom_addr", rom_addr, RESET_PC);
    restart_bubble("rst_stall");
    check("rst_stall_pc", out_pc, RESET_PC);
    run(1'b1, 4);

    // Random backpressure with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0)
        step(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'b0);
      else
        step(1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
    end
    run(1'b1, 6);

`ifdef FETCH_PERF_EN
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("perf_rst_fetched", perf_fetched, 32'd0);
    check("perf_rst_stall", perf_stall, 32'd0);
    check("perf_rst_flush", perf_flush, 32'd0);
    restart_bubble("perf");
    run(1'b1, 10);
    run(1'b0, 3);
    step(1'b1, 1'b1, 32'h300, 1'b0);
    check("perf_fetched_ge10", 32'(perf_fetched >= 32'd10), 32'd1);
    check("perf_stall", perf_stall, 32'd3);
    check("perf_flush", perf_flush, 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("perf_clr_fetched", perf_fetched, 32'd0);
    check("perf_clr_stall", perf_stall, 32'd0);
    check("perf_clr_flush", perf_flush, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
